// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and mux-select encodings for the multicycle controller.
// Revision 1.0
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IWB     = 4'd11,
    S_JEX     = 4'd12,
    S_JALEX   = 4'd13,
    S_JREX    = 4'd14,
    S_FAULT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: memory-wait cycle counter; expired flags count==limit (limit 0 never expires).
// Revision 1.0
`default_nettype none

module mc_wait_timer #(
  parameter int WCNT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [WCNT_W-1:0] limit,
  output logic              expired
);

  logic [WCNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (limit != '0) && (count == limit);

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS32 control FSM with memory-wait timeout and illegal-op fault.
// Optional MC_CONTROLLER_PERF_EN adds instret/cycles counters. Revision 1.0
`default_nettype none

module mc_controller
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int WCNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       ne,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       link,
  output logic       zeroext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       fault
`ifdef MC_CONTROLLER_PERF_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] cycles
`endif
);

  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);

  state_t state, next_state;
  logic   waiting, timer_clear, timer_en, expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  // Clearing on any state change is equivalent to clearing on entry to a wait state.
  assign waiting     = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timer_clear = (next_state != state);
  assign timer_en    = waiting && !mem_ready;

  mc_wait_timer #(.WCNT_W(WCNT_W)) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .limit   (WAIT_LIMIT),
    .expired (expired)
  );

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    ne         = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    link       = 1'b0;
    zeroext    = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = ALUSRCB_B;
    pcsrc      = PCSRC_ALURES;
    aluop      = ALUOP_ADD;
    fault      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          irwrite    = 1'b1;
          pcwrite    = 1'b1;
          alusrcb    = ALUSRCB_FOUR;
          next_state = S_DECODE;
        end else if (expired) begin
          next_state = S_FAULT;
        end
      end
      S_DECODE: begin
        alusrcb = ALUSRCB_IMMSH;
        case (op)
          OP_LW, OP_SW:    next_state = S_MEMADR;
          OP_RTYPE:        next_state = (funct == FN_JR) ? S_JREX : S_RTYPEEX;
          OP_BEQ, OP_BNE:  next_state = S_BREX;
          OP_ADDI:         next_state = S_ADDIEX;
          OP_ORI:          next_state = S_ORIEX;
          OP_J:            next_state = S_JEX;
          OP_JAL:          next_state = S_JALEX;
          default:         next_state = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = ALUSRCB_IMM;
        next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)    next_state = S_MEMWB;
        else if (expired) next_state = S_FAULT;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready)    next_state = S_FETCH;
        else if (expired) next_state = S_FAULT;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        next_state = S_FETCH;
      end
      S_BREX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        pcsrc      = PCSRC_ALUOUT;
        ne         = (op == OP_BNE);
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = ALUSRCB_IMM;
        next_state = S_IWB;
      end
      S_ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = ALUSRCB_IMM;
        aluop      = ALUOP_OR;
        zeroext    = 1'b1;
        next_state = S_IWB;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        zeroext    = (op == OP_ORI);
        next_state = S_FETCH;
      end
      S_JEX: begin
        pcwrite    = 1'b1;
        pcsrc      = PCSRC_JUMP;
        next_state = S_FETCH;
      end
      S_JALEX: begin
        pcwrite    = 1'b1;
        pcsrc      = PCSRC_JUMP;
        regwrite   = 1'b1;
        link       = 1'b1;
        next_state = S_FETCH;
      end
      S_JREX: begin
        pcwrite    = 1'b1;
        pcsrc      = PCSRC_REGA;
        next_state = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        next_state = S_FAULT;
      end
    endcase
  end

`ifdef MC_CONTROLLER_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycles  <= '0;
      instret <= '0;
    end else begin
      if (state != S_FAULT) cycles <= cycles + 32'd1;
      if ((next_state == S_FETCH) && (state != S_FETCH)) instret <= instret + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed scoreboard bench comparing per-cycle control outputs to expectations.
`default_nettype none

module tb_mc_controller;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       ne;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       link;
    logic       zeroext;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       fault;
  } outs_t;

  localparam outs_t E_FETCH_WAIT = '{mem_req: 1'b1, default: '0};
  localparam outs_t E_FETCH_GO   = '{mem_req: 1'b1, irwrite: 1'b1, pcwrite: 1'b1, alusrcb: 2'b01, default: '0};
  localparam outs_t E_DECODE     = '{alusrcb: 2'b11, default: '0};
  localparam outs_t E_MEMADR     = '{alusrca: 1'b1, alusrcb: 2'b10, default: '0};
  localparam outs_t E_MEMRD      = '{mem_req: 1'b1, iord: 1'b1, default: '0};
  localparam outs_t E_MEMWB      = '{regwrite: 1'b1, memtoreg: 1'b1, default: '0};
  localparam outs_t E_MEMWR      = '{mem_req: 1'b1, memwrite: 1'b1, iord: 1'b1, default: '0};
  localparam outs_t E_RTEX       = '{alusrca: 1'b1, aluop: 2'b10, default: '0};
  localparam outs_t E_RTWB       = '{regwrite: 1'b1, regdst: 1'b1, default: '0};
  localparam outs_t E_BEQ        = '{alusrca: 1'b1, aluop: 2'b01, branch: 1'b1, pcsrc: 2'b01, default: '0};
  localparam outs_t E_BNE        = '{alusrca: 1'b1, aluop: 2'b01, branch: 1'b1, pcsrc: 2'b01, ne: 1'b1, default: '0};
  localparam outs_t E_ADDIEX     = '{alusrca: 1'b1, alusrcb: 2'b10, default: '0};
  localparam outs_t E_ORIEX      = '{alusrca: 1'b1, alusrcb: 2'b10, aluop: 2'b11, zeroext: 1'b1, default: '0};
  localparam outs_t E_IWB_ADDI   = '{regwrite: 1'b1, default: '0};
  localparam outs_t E_IWB_ORI    = '{regwrite: 1'b1, zeroext: 1'b1, default: '0};
  localparam outs_t E_JEX        = '{pcwrite: 1'b1, pcsrc: 2'b10, default: '0};
  localparam outs_t E_JAL        = '{pcwrite: 1'b1, pcsrc: 2'b10, regwrite: 1'b1, link: 1'b1, default: '0};
  localparam outs_t E_JR         = '{pcwrite: 1'b1, pcsrc: 2'b11, default: '0};
  localparam outs_t E_FAULT      = '{fault: 1'b1, default: '0};

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, ne, regdst;
  logic       memtoreg, regwrite, link, zeroext, alusrca, fault;
  logic [1:0] alusrcb, pcsrc, aluop;
`ifdef MC_CONTROLLER_PERF_EN
  logic [31:0] instret, cycles;
`endif

  outs_t obs;
  assign obs = {mem_req, iord, memwrite, irwrite, pcwrite, branch, ne, regdst, memtoreg,
                regwrite, link, zeroext, alusrca, alusrcb, pcsrc, aluop, fault};

  always #5 clk = ~clk;

  mc_controller #(.WAIT_MAX(15), .WCNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .funct     (funct),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .pcwrite   (pcwrite),
    .branch    (branch),
    .ne        (ne),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .link      (link),
    .zeroext   (zeroext),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .fault     (fault)
`ifdef MC_CONTROLLER_PERF_EN
    ,
    .instret   (instret),
    .cycles    (cycles)
`endif
  );

  outs_t exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  // One clock cycle: drive mem_ready, queue the expectation, compare mid-cycle.
  task automatic cyc(input string tag, input logic rdy, input outs_t exp_v);
    outs_t e;
    string t;
    mem_ready = rdy;
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    cyc(tag, 1'b0, E_FETCH_WAIT);
    reset_n = 1'b1;
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    op        = 6'b000000;
    funct     = 6'b100000;
    @(posedge clk);
    #1;
    cyc("reset_state", 1'b0, E_FETCH_WAIT);
    reset_n = 1'b1;

    // R-type add, memory always ready
    set_instr(6'b000000, 6'b100000);
    cyc("rt_fetch", 1'b1, E_FETCH_GO);
    cyc("rt_decode", 1'b1, E_DECODE);
    cyc("rt_ex", 1'b1, E_RTEX);
    cyc("rt_wb", 1'b1, E_RTWB);

    // lw with three wait cycles in MEMRD
    set_instr(6'b100011, 6'b000000);
    cyc("lw_fetch", 1'b1, E_FETCH_GO);
    cyc("lw_decode", 1'b1, E_DECODE);
    cyc("lw_memadr", 1'b1, E_MEMADR);
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1'b0, E_MEMRD);
    cyc("lw_memrd_done", 1'b1, E_MEMRD);
    cyc("lw_memwb", 1'b1, E_MEMWB);

    // sw
    set_instr(6'b101011, 6'b000000);
    cyc("sw_fetch", 1'b1, E_FETCH_GO);
    cyc("sw_decode", 1'b1, E_DECODE);
    cyc("sw_memadr", 1'b1, E_MEMADR);
    cyc("sw_memwr", 1'b1, E_MEMWR);

    // bne then beq
    set_instr(6'b000101, 6'b000000);
    cyc("bne_fetch", 1'b1, E_FETCH_GO);
    cyc("bne_decode", 1'b1, E_DECODE);
    cyc("bne_ex", 1'b1, E_BNE);
    set_instr(6'b000100, 6'b000000);
    cyc("beq_fetch", 1'b1, E_FETCH_GO);
    cyc("beq_decode", 1'b1, E_DECODE);
    cyc("beq_ex", 1'b1, E_BEQ);

    // jr, jal, j
    set_instr(6'b000000, 6'b001000);
    cyc("jr_fetch", 1'b1, E_FETCH_GO);
    cyc("jr_decode", 1'b1, E_DECODE);
    cyc("jr_ex", 1'b1, E_JR);
    set_instr(6'b000011, 6'b000000);
    cyc("jal_fetch", 1'b1, E_FETCH_GO);
    cyc("jal_decode", 1'b1, E_DECODE);
    cyc("jal_ex", 1'b1, E_JAL);
    set_instr(6'b000010, 6'b000000);
    cyc("j_fetch", 1'b1, E_FETCH_GO);
    cyc("j_decode", 1'b1, E_DECODE);
    cyc("j_ex", 1'b1, E_JEX);

    // addi, ori
    set_instr(6'b001000, 6'b000000);
    cyc("addi_fetch", 1'b1, E_FETCH_GO);
    cyc("addi_decode", 1'b1, E_DECODE);
    cyc("addi_ex", 1'b1, E_ADDIEX);
    cyc("addi_wb", 1'b1, E_IWB_ADDI);
    set_instr(6'b001101, 6'b000000);
    cyc("ori_fetch", 1'b1, E_FETCH_GO);
    cyc("ori_decode", 1'b1, E_DECODE);
    cyc("ori_ex", 1'b1, E_ORIEX);
    cyc("ori_wb", 1'b1, E_IWB_ORI);

    // Fetch timeout: 15 completed waits, then the limit cycle without ready faults
    set_instr(6'b000000, 6'b100000);
    for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 1'b0, E_FETCH_WAIT);
    cyc("to_fault", 1'b0, E_FAULT);
    cyc("to_fault_hold", 1'b1, E_FAULT);
    pulse_reset("to_reset");

    // Ready on the limit cycle wins over the timeout
    for (int i = 0; i < 15; i++) cyc("edge_fetch_wait", 1'b0, E_FETCH_WAIT);
    cyc("edge_fetch_go", 1'b1, E_FETCH_GO);
    cyc("edge_decode", 1'b1, E_DECODE);
    cyc("edge_rt_ex", 1'b1, E_RTEX);
    cyc("edge_rt_wb", 1'b1, E_RTWB);

    // Illegal opcode: fault is absorbing until reset
    set_instr(6'b111111, 6'b000000);
    cyc("ill_fetch", 1'b1, E_FETCH_GO);
    cyc("ill_decode", 1'b1, E_DECODE);
    for (int i = 0; i < 20; i++) cyc("ill_fault_hold", 1'($urandom_range(0, 1)), E_FAULT);
    pulse_reset("ill_reset");

    // Mid-instruction reset returns straight to FETCH
    set_instr(6'b100011, 6'b000000);
    cyc("mid_fetch", 1'b1, E_FETCH_GO);
    cyc("mid_decode", 1'b1, E_DECODE);
    pulse_reset("mid_reset");
    set_instr(6'b000000, 6'b100000);
    cyc("post_fetch", 1'b1, E_FETCH_GO);
    cyc("post_decode", 1'b1, E_DECODE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM for the MIPS32 core. It replaces the single-cycle decode path when the shared-memory multicycle datapath is built.
- Sequences one instruction through fetch, decode, execute, memory and writeback over 3-5+ cycles. Drives PC/IR write enables, mux selects and ALU op class.
- Waits on a memory ready handshake and faults on illegal opcodes or memory timeout.

Parameters:
- WAIT_MAX, 15: maximum cycles to wait for mem_ready in a memory state. 0 disables the timeout.
- WCNT_W, 4: width of the wait counter. Must satisfy 2^WCNT_W > WAIT_MAX.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  store strobe, qualified by mem_req
- irwrite  out  1  IR load enable
- pcwrite  out  1  unconditional PC write
- branch  out  1  conditional PC write
- ne  out  1  invert the zero condition (bne)
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  writeback source: 1 = memory data
- regwrite  out  1  register file write enable
- link  out  1  write PC+4 to $31 (jal)
- zeroext  out  1  zero-extend the immediate (ori)
- alusrca  out  1  ALU A source: 0 = PC, 1 = A register
- alusrcb  out  2  ALU B source: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = A register (jr)
- aluop  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct, 11 = or
- fault  out  1  sticky fault flag

Behaviour:
- Reset (async, reset_n=0): state=FETCH, wait counter=0, fault=0. Every output not listed in a state is 0.
- FETCH: mem_req=1, iord=0.
  - mem_ready=1 (Mealy) → irwrite=1, pcwrite=1, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEMADR
  - R-type with funct=001000 → JREX
  - other R-type → RTYPEEX
  - beq/bne → BREX
  - addi → ADDIEX
  - ori → ORIEX
  - j → JEX
  - jal → JALEX
  - any other opcode → FAULT
- MEMADR: alusrca=1, alusrcb=10, aluop=00; go to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1; on mem_ready go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0; go to FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1; on mem_ready go to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10; go to RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1; go to FETCH.
- BREX: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01, ne=(op==000101); go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00; go to IWB.
- ORIEX: same as ADDIEX but aluop=11 and zeroext=1; go to IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. zeroext is held from ORIEX when the instruction is ori. Go to FETCH.
- JEX: pcwrite=1, pcsrc=10; go to FETCH.
- JALEX: pcwrite=1, pcsrc=10, regwrite=1, link=1; go to FETCH.
- JREX: pcwrite=1, pcsrc=11; go to FETCH.
- FAULT: fault=1 and all strobes 0. Absorbing until reset_n is asserted.
- Wait counter:
  - Clears on every entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle in those states while mem_ready=0.
  - If it equals WAIT_MAX with WAIT_MAX≠0 and mem_ready=0 → next state is FAULT.
  - mem_ready=1 in the same cycle as the limit wins: the access completes normally.
- Latency: R-type 4 cycles, lw 5, sw 4, branch 3, jump 3, each plus memory wait cycles.
- Reset asserted mid-instruction: immediately returns to FETCH; no partial strobes after the reset edge.

Optional Feature:
- Macro MC_CONTROLLER_PERF_EN.
- Defined: adds outputs instret[31:0] and cycles[31:0]. Both reset to 0.
  - cycles increments every cycle outside FAULT.
  - instret increments on each transition into FETCH from a non-FETCH state.
  - Both counters wrap modulo 2^32.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_pkg holds:
  - state_t enum
  - opcode and funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J, OP_JAL, FN_JR)
  - ALUSRCB_*, PCSRC_* and ALUOP_* encodings
- Sub-module mc_wait_timer: clear/enable/limit inputs, expired output. It holds the wait counter.

Test Plan:
- Reset release, mem_ready tied 1, op=000000 funct=100000 → irwrite and pcwrite pulse in cycle 0; regwrite=1, regdst=1 in cycle 3; back in FETCH in cycle 4.
- lw (op=100011) with mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles, then MEMWB with memtoreg=1, regwrite=1; total 8 cycles.
- bne (op=000101) → BREX asserts branch=1, ne=1, pcsrc=01, aluop=01. beq (op=000100) → ne=0.
- jr (op=0, funct=001000) → DECODE goes to JREX: pcsrc=11, pcwrite=1, regwrite=0. jal (op=000011) → link=1, regwrite=1, pcsrc=10.
- op=111111 → FAULT on the cycle after DECODE, fault=1 persists for 20 cycles; pulse reset_n low → FETCH, fault=0.
- WAIT_MAX=15, mem_ready held 0 in FETCH → FAULT after exactly 15 wait cycles. Repeat with mem_ready=1 on cycle 15 → DECODE, no fault.
